demux_1x2_stream: RTL and testbench

Registered 1-to-2 stream demultiplexer, the steering counterpart of the datapath 2:1 select: one valid/ready input stream is routed word-by-word to output port A or B according to a per-word select bit. Each output has a 2-entry buffer, so outputs are registered and each port sustains one word per cycle. It sits between a single producer, such as the writeback or result bus, and two independent consumers.

---
 rtl/demux_1x2_stream.sv | 100 ++++++++++
 tb/tb_demux_1x2_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demux with a 2-entry FIFO per output port.
// Optional handshake counters on a_xfer_cnt/b_xfer_cnt when DEMUX_XFER_CNT_EN is defined.
module demux_1x2_stream #(
    parameter int bitwidth = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sel,
    input  logic [bitwidth-1:0] in_data,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [bitwidth-1:0] a_data,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [bitwidth-1:0] b_data
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [15:0]         a_xfer_cnt,
    output logic [15:0]         b_xfer_cnt
`endif
);

    logic [bitwidth-1:0] a_mem [2];
    logic [bitwidth-1:0] b_mem [2];
    logic                a_wp, a_rp;
    logic                b_wp, b_rp;
    logic [1:0]          a_cnt, b_cnt;
    logic                push_a, push_b;
    logic                pop_a, pop_b;

    // Head-of-line blocking: only the selected port's occupancy gates input.
    always_comb begin
        in_ready = in_sel ? (b_cnt != 2'd2) : (a_cnt != 2'd2);
        push_a   = in_valid && in_ready && !in_sel;
        push_b   = in_valid && in_ready && in_sel;
        pop_a    = a_valid && a_ready;
        pop_b    = b_valid && b_ready;
    end

    assign a_valid = (a_cnt != 2'd0);
    assign b_valid = (b_cnt != 2'd0);
    assign a_data  = a_mem[a_rp];
    assign b_data  = b_mem[b_rp];

    // Port A pointers and occupancy; push and pop together leave cnt unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_wp  <= 1'b0;
            a_rp  <= 1'b0;
            a_cnt <= 2'd0;
        end else begin
            if (push_a) a_wp <= ~a_wp;
            if (pop_a)  a_rp <= ~a_rp;
            case ({push_a, pop_a})
                2'b10:   a_cnt <= a_cnt + 2'd1;
                2'b01:   a_cnt <= a_cnt - 2'd1;
                default: a_cnt <= a_cnt;
            endcase
        end
    end

    // Port B pointers and occupancy; mirrors port A.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_wp  <= 1'b0;
            b_rp  <= 1'b0;
            b_cnt <= 2'd0;
        end else begin
            if (push_b) b_wp <= ~b_wp;
            if (pop_b)  b_rp <= ~b_rp;
            case ({push_b, pop_b})
                2'b10:   b_cnt <= b_cnt + 2'd1;
                2'b01:   b_cnt <= b_cnt - 2'd1;
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    // Entry storage is not reset; contents only matter while valid.
    always_ff @(posedge clk) begin
        if (!reset && push_a) a_mem[a_wp] <= in_data;
        if (!reset && push_b) b_mem[b_wp] <= in_data;
    end

`ifdef DEMUX_XFER_CNT_EN
    // Completed output handshakes per port, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_xfer_cnt <= 16'd0;
            b_xfer_cnt <= 16'd0;
        end else begin
            if (pop_a) a_xfer_cnt <= a_xfer_cnt + 16'd1;
            if (pop_b) b_xfer_cnt <= b_xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Self-checking bench for demux_1x2_stream: queue model plus directed literals.
// Counter checks are compiled in when DEMUX_XFER_CNT_EN is defined.
module tb_demux_1x2_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [31:0] in_data;
    logic        a_valid, a_ready;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [31:0] b_data;
`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] a_xfer_cnt, b_xfer_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          ca = 0;
    int          cb = 0;
    logic        acc;

    always #5 clk = ~clk;

    demux_1x2_stream #(.bitwidth(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_XFER_CNT_EN
        ,
        .a_xfer_cnt (a_xfer_cnt),
        .b_xfer_cnt (b_xfer_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Outputs required by the queue model in the current cycle.
    task automatic compare();
        logic exp_rdy;
        exp_rdy = (in_sel ? qb.size() : qa.size()) != 2;
        chk("a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
        chk("b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (qa.size() != 0) chk("a_data", a_data, qa[0]);
        if (qb.size() != 0) chk("b_data", b_data, qb[0]);
`ifdef DEMUX_XFER_CNT_EN
        chk("a_xfer_cnt", {16'b0, a_xfer_cnt}, ca);
        chk("b_xfer_cnt", {16'b0, b_xfer_cnt}, cb);
`endif
    endtask

    // One clock cycle: drive, compare, then advance the model.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [31:0] d, input logic ar,
                        input logic br, output logic accepted);
        logic pa, pb;
        @(negedge clk);
        reset    = r;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
        compare();
        accepted = v && !r && ((s ? qb.size() : qa.size()) != 2);
        pa = !r && ar && (qa.size() != 0);
        pb = !r && br && (qb.size() != 0);
        @(posedge clk);
        #1;
        if (r) begin
            qa.delete();
            qb.delete();
            ca = 0;
            cb = 0;
        end else begin
            if (pa) begin
                void'(qa.pop_front());
                ca = (ca + 1) % 65536;
            end
            if (pb) begin
                void'(qb.pop_front());
                cb = (cb + 1) % 65536;
            end
            if (accepted) begin
                if (s) qb.push_back(d);
                else   qa.push_back(d);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        chk("idle_a_valid", {31'b0, a_valid}, 32'd0);
        chk("idle_b_valid", {31'b0, b_valid}, 32'd0);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef DEMUX_XFER_CNT_EN
        chk("idle_a_cnt", {16'b0, a_xfer_cnt}, 32'd0);
        chk("idle_b_cnt", {16'b0, b_xfer_cnt}, 32'd0);
`endif

        // Alternating stream, both consumers ready.
        step(1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, acc);
        chk("alt1_a_valid", {31'b0, a_valid}, 32'd1);
        chk("alt1_a_data", a_data, 32'h11);
        step(1'b0, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1, acc);
        chk("alt2_b_data", b_data, 32'h22);
        chk("alt2_a_valid", {31'b0, a_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 1'b1, acc);
        chk("alt3_a_data", a_data, 32'h33);
        chk("alt3_b_valid", {31'b0, b_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("alt4_a_valid", {31'b0, a_valid}, 32'd0);

        // A stalled: two words absorbed, third blocked, B word behind it.
        step(1'b0, 1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, acc);
        chk("stall_full_rdy", {31'b0, in_ready}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, acc);
        chk("stall_hol_rdy", {31'b0, in_ready}, 32'd0);
        chk("stall_head", a_data, 32'hA0);
        // Pop at cnt=2: slot frees only for the next cycle.
        step(1'b0, 1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, acc);
        chk("drain1_head", a_data, 32'hA1);
        chk("drain1_rdy", {31'b0, in_ready}, 32'd1);
        // Push and pop at cnt=1: occupancy stays 1, order kept.
        step(1'b0, 1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, acc);
        chk("drain2_head", a_data, 32'hA2);
        chk("drain2_valid", {31'b0, a_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("drain3_valid", {31'b0, a_valid}, 32'd0);

        // Reset with A full and B holding one word.
        step(1'b0, 1'b1, 1'b0, 32'hC0, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 1'b0, 32'hC1, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 1'b1, 32'hD0, 1'b0, 1'b0, acc);
        chk("pre_rst_b_valid", {31'b0, b_valid}, 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'hD1, 1'b1, 1'b1, acc);
        chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("post_rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("post_rst_b_valid", {31'b0, b_valid}, 32'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6,
                 acc);
        end

`ifdef DEMUX_XFER_CNT_EN
        // Drive A handshakes until the counter sits at 0xFFFF, then wrap it.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 70000 && ca != 65535; i++)
            step(1'b0, 1'b1, 1'b0, i, 1'b1, 1'b0, acc);
        chk("cnt_preload", {16'b0, a_xfer_cnt}, 32'h0000FFFF);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("cnt_wrap", {16'b0, a_xfer_cnt}, 32'h0);
        chk("cnt_b_quiet", {16'b0, b_xfer_cnt}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
